// File: rtl/sequence_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sequence_scan_pkg
// Description : Shared definitions for the sequence scan scheduler. This
//               package holds the FSM state encoding and the width and
//               saturation limit of the optional hit counter.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sequence_scan_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_LOAD   = S_LOAD,
        ST_SHIFT  = S_SHIFT,
        ST_DRAIN  = S_DRAIN,
        ST_REPORT = S_REPORT
    } state_t;

    localparam int                    HIT_CNT_W   = 8;
    localparam logic [HIT_CNT_W-1:0]  HIT_CNT_MAX = 8'd255;

endpackage
`default_nettype wire

// File: rtl/sequence_scan_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. It searches the request vector starting
//               one position after the last grant and wraps around. The
//               first valid requester it finds receives the grant.
// Ports       : req   [NUM_REQ]  request vector
//               last  [ID_W]     id of the previous winner
//               grant [NUM_REQ]  one-hot grant (all zero when no request)
//               id    [ID_W]     index of the granted requester
//               any              at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    id,
    output logic               any
);

    int w_idx;

    always_comb begin
        grant = '0;
        id    = '0;
        any   = 1'b0;
        w_idx = 0;
        // Offsets 1..NUM_REQ make the last winner the lowest priority.
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = (int'(last) + i) % NUM_REQ;
            if (!any && req[w_idx]) begin
                any          = 1'b1;
                grant[w_idx] = 1'b1;
                id           = ID_W'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sequence_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sequence_scan_scheduler
// Description : Shares one serial sequence detector among NUM_REQ
//               requesters. Each accepted word goes through these steps:
//               clear the detector, shift the word out LSB first, wait
//               DET_LAT drain cycles, then report whether det_in was seen
//               high.
// Ports       : clk, Reset (async, active-high)
//               req_valid/req_data/req_ready : requester handshake
//               det_clr/ser_data/ser_valid   : serial detector drive
//               det_in                       : detector hit input
//               res_valid/res_id/res_hit     : per-word result strobe
//               hit_count                    : count of hit words
// Config      : define SEQ_SCAN_HITCOUNT_EN to enable the saturating hit
//               counter. When the macro is undefined, hit_count is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sequence_scan_scheduler
    import sequence_scan_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 4,
    parameter  int DET_LAT = 1,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       Reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       det_clr,
    output logic                       ser_data,
    output logic                       ser_valid,
    input  logic                       det_in,
    output logic                       res_valid,
    output logic [ID_W-1:0]            res_id,
    output logic                       res_hit,
    output logic [HIT_CNT_W-1:0]       hit_count
);

    localparam int CNT_W = $clog2(WIDTH + DET_LAT + 1);

    state_t               r_state, w_next;
    logic [CNT_W-1:0]     r_cnt, w_cnt_next;
    logic [WIDTH-1:0]     r_shift;
    logic [ID_W-1:0]      r_id, r_ptr;
    logic                 r_hit;
    logic                 r_det_clr, r_ser_data, r_ser_valid;
    logic                 r_res_valid, r_res_hit;
    logic [ID_W-1:0]      r_res_id;
    logic [NUM_REQ-1:0]   w_grant;
    logic [ID_W-1:0]      w_gid;
    logic                 w_any, w_accept, w_hit_now;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req_valid),
        .last  (r_ptr),
        .grant (w_grant),
        .id    (w_gid),
        .any   (w_any)
    );

    // Only the IDLE state exposes the grant. Requests seen in any other
    // state are ignored.
    assign req_ready = (r_state == ST_IDLE) ? w_grant : '0;

    // Hit flag including this cycle's det_in. det_in counts only while
    // shifting or draining.
    assign w_hit_now = r_hit | (((r_state == ST_SHIFT) || (r_state == ST_DRAIN)) & det_in);

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_accept   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_accept = 1'b1;
                    w_next   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_cnt_next = '0;
                w_next     = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_cnt_next = '0;
                    w_next     = (DET_LAT == 0) ? ST_REPORT : ST_DRAIN;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (r_cnt == CNT_W'(DET_LAT - 1)) begin
                    w_cnt_next = '0;
                    w_next     = ST_REPORT;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_REPORT: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Every output register is loaded from the next state. Its value
    // therefore lines up with the cycle in which the FSM occupies that state.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_id        <= '0;
            r_ptr       <= ID_W'(NUM_REQ - 1);
            r_hit       <= 1'b0;
            r_det_clr   <= 1'b0;
            r_ser_data  <= 1'b0;
            r_ser_valid <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_hit   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_shift <= req_data[int'(w_gid)*WIDTH +: WIDTH];
                r_id    <= w_gid;
                r_ptr   <= w_gid;
            end else if (w_next == ST_SHIFT) begin
                r_shift <= r_shift >> 1;
            end
            r_hit       <= (r_state == ST_LOAD) ? 1'b0 : w_hit_now;
            r_det_clr   <= (w_next == ST_LOAD);
            r_ser_valid <= (w_next == ST_SHIFT);
            r_ser_data  <= (w_next == ST_SHIFT) & r_shift[0];
            r_res_valid <= (w_next == ST_REPORT);
            r_res_id    <= (w_next == ST_REPORT) ? r_id : '0;
            r_res_hit   <= (w_next == ST_REPORT) & w_hit_now;
        end
    end

    assign det_clr   = r_det_clr;
    assign ser_data  = r_ser_data;
    assign ser_valid = r_ser_valid;
    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign res_hit   = r_res_hit;

`ifdef SEQ_SCAN_HITCOUNT_EN
    logic [HIT_CNT_W-1:0] r_hit_cnt;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_hit_cnt <= '0;
        end else if ((w_next == ST_REPORT) && w_hit_now && (r_hit_cnt != HIT_CNT_MAX)) begin
            r_hit_cnt <= r_hit_cnt + 1'b1;
        end
    end

    assign hit_count = r_hit_cnt;
`else
    assign hit_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sequence_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sequence_scan_scheduler
// Description : Self-checking bench for sequence_scan_scheduler. A reference
//               model predicts the round-robin winner, the serial bit timing,
//               the hit result and the (optional) hit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sequence_scan_scheduler;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 4;
    localparam int DET_LAT = 1;
    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int DW      = NUM_REQ * WIDTH;
    localparam int RPT     = WIDTH + DET_LAT + 2;   // result cycle after accept

    logic               clk = 1'b0;
    logic               Reset;
    logic [NUM_REQ-1:0] req_valid;
    logic [DW-1:0]      req_data;
    logic [NUM_REQ-1:0] req_ready;
    logic               det_clr, ser_data, ser_valid, det_in;
    logic               res_valid, res_hit;
    logic [ID_W-1:0]    res_id;
    logic [7:0]         hit_count;

    int n_checks = 0;
    int n_errors = 0;
    int rr_last  = NUM_REQ - 1;   // model: last granted requester
    int hit_model = 0;            // model: saturating hit-word count

    always #5 clk = ~clk;

    sequence_scan_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .DET_LAT(DET_LAT)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .det_clr   (det_clr),
        .ser_data  (ser_data),
        .ser_valid (ser_valid),
        .det_in    (det_in),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_hit   (res_hit),
        .hit_count (hit_count)
    );

    function automatic int exp_hit_count();
`ifdef SEQ_SCAN_HITCOUNT_EN
        return hit_model;
`else
        return 0;
`endif
    endfunction

    task automatic apply_reset();
        req_valid = '0;
        det_in    = 1'b0;
        Reset     = 1'b1;
        @(posedge clk); #1;
        Reset     = 1'b0;
        rr_last   = NUM_REQ - 1;
        hit_model = 0;
    endtask

    // One word from the accept cycle (0) through the result cycle (RPT).
    // det_pat[k] drives det_in during cycle k. req_data is scrambled after
    // the accept, so the serial bits must come from the word that was
    // latched at accept time.
    task automatic run_word(input logic [NUM_REQ-1:0] valids, input logic [DW-1:0] datas,
                            input logic [RPT:0] det_pat, input bit keep, output int got_id);
        int               win;
        logic [WIDTH-1:0] word;
        logic             exp_hit;
        logic [NUM_REQ-1:0] exp_ready;
        logic [3:0]       obs, expv;
        @(posedge clk); #1;
        req_valid = valids;
        req_data  = datas;
        det_in    = det_pat[0];
        win = -1;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (win < 0 && valids[(rr_last + i) % NUM_REQ]) win = (rr_last + i) % NUM_REQ;
        end
        word      = datas[win*WIDTH +: WIDTH];
        exp_ready = '0;
        exp_ready[win] = 1'b1;
        exp_hit   = 1'b0;
        for (int k = 2; k <= RPT - 1; k++) exp_hit |= det_pat[k];
        #1;
        n_checks++;
        if (req_ready !== exp_ready) begin
            n_errors++;
            $display("FAIL req_ready: got %b expected %b", req_ready, exp_ready);
        end
        n_checks++;
        if (int'(hit_count) !== exp_hit_count()) begin
            n_errors++;
            $display("FAIL hit_count: got %0d expected %0d", hit_count, exp_hit_count());
        end
        rr_last = win;
        got_id  = -1;
        for (int k = 1; k <= RPT; k++) begin
            @(posedge clk); #1;
            det_in   = det_pat[k];
            req_data = DW'($urandom);
            #1;
            obs  = {|req_ready, det_clr, ser_valid, res_valid};
            expv = {1'b0, k == 1, (k >= 2 && k <= WIDTH + 1), k == RPT};
            n_checks++;
            if (obs !== expv) begin
                n_errors++;
                $display("FAIL ctrl cycle %0d: got {rdy,clr,sv,rv}=%b expected %b", k, obs, expv);
            end
            if (k >= 2 && k <= WIDTH + 1) begin
                n_checks++;
                if (ser_data !== word[k-2]) begin
                    n_errors++;
                    $display("FAIL ser_data bit %0d: got %b expected %b", k - 2, ser_data, word[k-2]);
                end
            end
            if (k == RPT) begin
                got_id = int'(res_id);
                n_checks++;
                if (got_id !== win || res_hit !== exp_hit) begin
                    n_errors++;
                    $display("FAIL result: got id=%0d hit=%b expected id=%0d hit=%b",
                             got_id, res_hit, win, exp_hit);
                end
            end
        end
        det_in = 1'b0;
        if (!keep) req_valid = '0;
        if (exp_hit && hit_model < 255) hit_model++;
    endtask

    task automatic test_reset();
        logic [14:0] obs;
        req_data = '0;
        apply_reset();
        Reset = 1'b1;
        #1;
        obs = {req_ready, det_clr, ser_data, ser_valid, res_valid, res_id, res_hit, hit_count};
        n_checks++;
        if (obs !== '0) begin
            n_errors++;
            $display("FAIL reset outputs: got %b expected 0", obs);
        end
        @(posedge clk); #1;
        Reset = 1'b0;
    endtask

    task automatic test_single_word();
        int id;
        // req0 word 1011, detector fires in the third shift cycle (cycle 4)
        run_word(4'b0001, 16'h000B, 8'b0001_0000, 1'b0, id);
    endtask

    task automatic test_reset_mid_word();
        logic [14:0] obs;
        int          id;
        @(posedge clk); #1;
        req_valid = 4'b0100;
        req_data  = DW'($urandom);
        @(posedge clk); #1;           // LOAD
        req_valid = '0;
        @(posedge clk); @(posedge clk); #1;   // second SHIFT cycle
        n_checks++;
        if (ser_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL mid-shift ser_valid: got %b expected 1", ser_valid);
        end
        Reset = 1'b1;
        #1;
        obs = {req_ready, det_clr, ser_data, ser_valid, res_valid, res_id, res_hit, hit_count};
        n_checks++;
        if (obs !== '0) begin
            n_errors++;
            $display("FAIL async reset outputs: got %b expected 0", obs);
        end
        @(posedge clk); #1;
        Reset     = 1'b0;
        rr_last   = NUM_REQ - 1;
        hit_model = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (res_valid !== 1'b0 || ser_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL post-reset idle: got rv=%b sv=%b expected 0,0", res_valid, ser_valid);
            end
        end
        run_word(4'b1111, DW'($urandom), '0, 1'b0, id);
        n_checks++;
        if (id !== 0) begin
            n_errors++;
            $display("FAIL first grant after reset: got %0d expected 0", id);
        end
    endtask

    task automatic test_round_robin();
        int id;
        apply_reset();
        for (int w = 0; w < 5; w++) begin
            run_word(4'b1111, DW'($urandom), (RPT+1)'($urandom), 1'b1, id);
            n_checks++;
            if (id !== w % NUM_REQ) begin
                n_errors++;
                $display("FAIL rr order word %0d: got %0d expected %0d", w, id, w % NUM_REQ);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_drain_and_ignored();
        int id;
        run_word(4'b0010, DW'($urandom), 8'b0100_0000, 1'b0, id);  // DRAIN only
        run_word(4'b1000, DW'($urandom), 8'b1000_0011, 1'b0, id);  // IDLE/LOAD/REPORT only
    endtask

    task automatic test_random();
        int id;
        for (int w = 0; w < 40; w++) begin
            run_word(NUM_REQ'($urandom_range(1, 15)), DW'($urandom),
                     (RPT+1)'($urandom) & (RPT+1)'($urandom), 1'b0, id);
        end
    endtask

    task automatic test_hit_saturation();
        int          id;
        logic [RPT:0] pat;
        for (int w = 0; w < 300; w++) begin
            pat = '0;
            pat[$urandom_range(2, WIDTH + 1)] = 1'b1;
            run_word(NUM_REQ'($urandom_range(1, 15)), DW'($urandom), pat, 1'b0, id);
        end
        @(posedge clk); #1;
        n_checks++;
        if (int'(hit_count) !== exp_hit_count()) begin
            n_errors++;
            $display("FAIL hit_count final: got %0d expected %0d", hit_count, exp_hit_count());
        end
    endtask

    initial begin
        Reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        det_in    = 1'b0;
        test_reset();
        test_single_word();
        test_reset_mid_word();
        test_round_robin();
        test_drain_and_ignored();
        test_random();
        test_hit_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
